// File: rtl/morse_cmd_scheduler.sv
// morse_cmd_scheduler: buffers keypad commands in a small FIFO, owns the
// mapper configuration (mode, long-press threshold) and dispatches each
// command in order to the text or Morse consumer over valid/ready.
module morse_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned THR_DEFAULT  = 25_000_000,
  parameter int unsigned THR_STEP     = 5_000_000,
  parameter int unsigned THR_MIN      = 5_000_000,
  parameter int unsigned THR_MAX      = 50_000_000,
  parameter int unsigned SEND_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [10:0] cmd_in,
  output logic [1:0]  mode,
  output logic [31:0] timer_threshold,
  output logic        freeze_ext,
  output logic        txt_valid,
  input  logic        txt_ready,
  output logic [10:0] txt_data,
  output logic        mrs_valid,
  input  logic        mrs_ready,
  output logic [10:0] mrs_data,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(SEND_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;

  localparam logic [10:0] W_LONG_ENTER = 11'h540;
  localparam logic [10:0] W_UP         = 11'h004;
  localparam logic [10:0] W_DOWN       = 11'h008;

  logic [10:0]      mem [FIFO_DEPTH];
  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [10:0]      hold_q, hold_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      thr_q, thr_d;
  logic             freeze_q, freeze_d;
  logic             txt_valid_q, txt_valid_d, mrs_valid_q, mrs_valid_d;
  logic [10:0]      txt_data_q, txt_data_d, mrs_data_q, mrs_data_d;
  logic [7:0]       drop_q, drop_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             fifo_full, pop, push, push_drop, tmo_drop;
  logic [10:0]      head;
  logic [32:0]      thr_ext, thr_up, thr_dn;
  logic [8:0]       drop_sum;

  assign mode            = mode_q;
  assign timer_threshold = thr_q;
  assign freeze_ext      = freeze_q;
  assign txt_valid       = txt_valid_q;
  assign txt_data        = txt_data_q;
  assign mrs_valid       = mrs_valid_q;
  assign mrs_data        = mrs_data_q;
  assign drop_cnt        = drop_q;

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cmd_in;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      mode_q      <= 2'd0;
      thr_q       <= 32'(THR_DEFAULT);
      freeze_q    <= 1'b0;
      txt_valid_q <= 1'b0;
      txt_data_q  <= '0;
      mrs_valid_q <= 1'b0;
      mrs_data_q  <= '0;
      drop_q      <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      freeze_q    <= freeze_d;
      txt_valid_q <= txt_valid_d;
      txt_data_q  <= txt_data_d;
      mrs_valid_q <= mrs_valid_d;
      mrs_data_q  <= mrs_data_d;
      drop_q      <= drop_d;
      tmo_q       <= tmo_d;
    end
  end

  // FIFO bookkeeping, IDLE/DECODE/SEND sequencing and config updates.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    txt_valid_d = txt_valid_q;
    txt_data_d  = txt_data_q;
    mrs_valid_d = mrs_valid_q;
    mrs_data_d  = mrs_data_q;
    tmo_d       = tmo_q;
    tmo_drop    = 1'b0;

    head      = mem[rd_ptr_q];
    fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = (state_q == S_IDLE) && (count_q != '0);
    push      = cmd_valid && (!fifo_full || pop);
    push_drop = cmd_valid && fifo_full && !pop;

    // Threshold math is one bit wider so the clamps never see a wrap.
    thr_ext = {1'b0, thr_q};
    thr_up  = thr_ext + 33'(THR_STEP);
    if (thr_up > 33'(THR_MAX)) thr_up = 33'(THR_MAX);
    if (thr_ext < (33'(THR_MIN) + 33'(THR_STEP))) thr_dn = 33'(THR_MIN);
    else                                          thr_dn = thr_ext - 33'(THR_STEP);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          hold_d  = head;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        if (hold_q == W_LONG_ENTER) begin
          mode_d = (mode_q >= 2'd2) ? 2'd0 : mode_q + 2'd1;
        end else if (mode_q == 2'd2 && hold_q == W_UP) begin
          thr_d = 32'(thr_up);
        end else if (mode_q == 2'd2 && hold_q == W_DOWN) begin
          thr_d = 32'(thr_dn);
        end else if (mode_q == 2'd0) begin
          txt_valid_d = 1'b1;
          txt_data_d  = hold_q;
          tmo_d       = TMO_W'(1);
          state_d     = S_SEND;
        end else if (mode_q == 2'd1) begin
          mrs_valid_d = 1'b1;
          mrs_data_d  = hold_q;
          tmo_d       = TMO_W'(1);
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if ((txt_valid_q && txt_ready) || (mrs_valid_q && mrs_ready)) begin
          txt_valid_d = 1'b0;
          mrs_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (tmo_q >= TMO_W'(SEND_TIMEOUT)) begin
          txt_valid_d = 1'b0;
          mrs_valid_d = 1'b0;
          tmo_drop    = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    // A FIFO drop and a SEND timeout may coincide; count both.
    drop_sum = 9'(drop_q) + 9'(push_drop) + 9'(tmo_drop);
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

    // Freeze near-full, and across the DECODE cycle of a mode switch.
    freeze_d = (count_d >= CNT_W'(FIFO_DEPTH - 1)) || (pop && head == W_LONG_ENTER);
  end

endmodule

// File: doc/morse_cmd_scheduler.md
# morse_cmd_scheduler

Sits between the keypad command mapper and the command consumers (text composer, Morse encoder) and owns the configuration that mapper runs under. It buffers incoming 11-bit commands in a small FIFO and dispatches each one in order over a valid/ready handshake to the consumer selected by the current mode. It executes mode-switch and threshold-adjust commands itself. It throttles the keypad through `freeze_ext` when the buffer is about to overflow.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: command buffer depth; power of two, ≥ 2.
- `THR_DEFAULT`, default 25_000_000: reset value of `timer_threshold`.
- `THR_STEP`, default 5_000_000: threshold adjust step.
- `THR_MIN`, default 5_000_000: lower saturation bound.
- `THR_MAX`, default 50_000_000: upper saturation bound.
- `SEND_TIMEOUT`, default 1_000_000: maximum number of SEND cycles before a stalled command is discarded.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: single-cycle command strobe.
- `cmd_in` in 11: command word; {type[10:8], data[7:0]}.
- `mode` out 2: 0 = Alpha, 1 = Morse, 2 = Setting; drives the mapper.
- `timer_threshold` out 32: long-press threshold; drives the mapper.
- `freeze_ext` out 1: keypad freeze request to the mapper.
- `txt_valid` out 1, `txt_ready` in 1, `txt_data` out 11: text consumer channel.
- `mrs_valid` out 1, `mrs_ready` in 1, `mrs_data` out 11: Morse consumer channel.
- `drop_cnt` out 8: saturating count of lost commands.

## Operation
FIFO:
- `cmd_valid`=1 while count < `FIFO_DEPTH` → the word is written at that edge.
- `cmd_valid`=1 while full → the word is discarded and `drop_cnt` increments, saturating at 255.
- Push and pop in the same cycle while full → the push is accepted and count is unchanged.

FSM states: IDLE, DECODE, SEND.
- IDLE: FIFO not empty → pop head into the hold register, go to DECODE.
- DECODE: classify the held word against the current `mode`, in priority order:
  1. type 3'b101 with data 8'h40 (long ENTER) → `mode` advances 0→1→2→0; go to IDLE.
  2. `mode`=2, type 3'b000, data 8'h04 (UP) → `timer_threshold` = min(thr + `THR_STEP`, `THR_MAX`); go to IDLE.
  3. `mode`=2, type 3'b000, data 8'h08 (DOWN) → `timer_threshold` = max(thr − `THR_STEP`, `THR_MIN`); go to IDLE.
  4. `mode`=2, any other word → consumed silently, not counted; go to IDLE.
  5. `mode`=0 → load `txt_data`, set `txt_valid`; go to SEND.
  6. `mode`=1 → load `mrs_data`, set `mrs_valid`; go to SEND.
  7. `mode`=3 (illegal) → treated as case 4.
- SEND: hold the valid signal and data stable until the selected ready is seen.
  - valid & ready at an edge → clear valid, go to IDLE.
  - Timeout counter reaches `SEND_TIMEOUT` → clear valid, increment `drop_cnt` (saturating), go to IDLE.
- Mode is evaluated at dequeue, never at enqueue. Commands queued behind a mode switch are therefore routed under the new mode.
- Threshold arithmetic is 33-bit with clamping; no wrap-around.
- Only one consumer valid is ever high at a time.

Freeze:
- `freeze_ext` is registered and equals (next count ≥ `FIFO_DEPTH` − 1).
- It is also held high during any DECODE cycle that changes `mode`.

## Timing
- Reset values:
  - `mode`=0, `timer_threshold`=`THR_DEFAULT`.
  - `freeze_ext`, `txt_valid`, `mrs_valid` = 0.
  - `txt_data`, `mrs_data` = 0, `drop_cnt`=0.
  - FIFO empty, FSM in IDLE.
- Reset asserted mid-operation: all of the above apply immediately and asynchronously. Any queued or in-flight command is lost and not counted.
- Forward latency: word written at edge N with the FIFO empty and FSM in IDLE → pop at N+1 → valid high after edge N+2.
- Configuration latency: `mode` and `timer_threshold` update after edge N+2.
- Throughput: at most one command per 3 cycles when ready is constantly high.
- The SEND timeout counter clears on entry to SEND. The first SEND cycle counts as 1.
- Ready is ignored outside SEND. Ready asserted in the same cycle valid rises completes the transfer at that edge.

## Test plan
- Reset, `mode`=0; push 8'h41 type 0 with `txt_ready`=1 → `txt_valid` pulses one cycle, 2 cycles after the push, with `txt_data`=11'h041; `mrs_valid` stays 0.
- Push long ENTER (11'h540) → `mode`=1, nothing forwarded. Then push 11'h301 with `mrs_ready`=1 → `mrs_data`=11'h301.
- Push long ENTER twice from reset (`mode`=2). Then push UP ×6 → `timer_threshold` reads 30M, 35M, 40M, 45M, 50M, 50M. Then push DOWN ×10 → saturates at 5_000_000.
- Hold `txt_ready`=0 and push 6 commands back-to-back → `freeze_ext` rises when count reaches 3, the 6th push is dropped, and `drop_cnt`=1. Release ready → the 5 remaining commands are delivered in order.
- Hold `txt_ready`=0 with `SEND_TIMEOUT`=16 → `txt_valid` drops after 16 SEND cycles, `drop_cnt` increments, and the next queued command dispatches.
- Assert `rst` while in SEND with 2 commands queued → `txt_valid`=0, FIFO empty and `mode`=0 immediately; nothing is delivered after `rst` deasserts.
